// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: frame-synchronous test-pattern selector with auto/step advance and VS-loss watchdog
module vga_pattern_sequencer #(
  parameter int   NUM_PAT     = 8,
  parameter int   SEL_W       = 3,
  parameter int   HOLD_FRAMES = 60,
  parameter int   CNT_W       = 8,
  parameter logic VS_POL      = 1'b0,
  parameter int   VS_TIMEOUT  = 840000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VGA_VS,
  input  logic             VGA_DE,
  input  logic             AUTO,
  input  logic             STEP,
  output logic [SEL_W-1:0] PAT_SEL,
  output logic             SWITCH,
  output logic [CNT_W-1:0] FRAME_CNT,
  output logic             LOCKED
);
  localparam int               WD_W    = $clog2(VS_TIMEOUT + 1);
  localparam logic [SEL_W-1:0] LAST    = SEL_W'(NUM_PAT - 1);
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WD_W-1:0]  WD_LIM  = WD_W'(VS_TIMEOUT);
  localparam logic [WD_W-1:0]  WD_PRE  = WD_W'(VS_TIMEOUT - 1);

  typedef enum logic {SYNC, SHOW} state_t;

  state_t           state_q, state_d;
  logic             vs1_q, vs2_q;
  logic             pend_q, pend_d;
  logic             sw_q, sw_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             fb, adv, expire;

  always_comb begin
    fb      = (vs1_q == VS_POL) && (vs2_q != VS_POL) && !VGA_DE;
    expire  = !fb && (wd_q == WD_PRE);
    adv     = fb && (state_q == SHOW) && (pend_q || (AUTO && cnt_q >= HOLD_M1));
    sel_d   = adv ? ((sel_q == LAST) ? '0 : sel_q + 1'b1) : sel_q;
    sw_d    = adv;
    pend_d  = adv ? 1'b0 : (pend_q | STEP);
    wd_d    = fb ? '0 : ((wd_q == WD_LIM) ? wd_q : wd_q + 1'b1);
    state_d = fb ? SHOW : (expire ? SYNC : state_q);
    cnt_d   = cnt_q;
    if (fb)
      cnt_d = (state_q == SYNC || adv) ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
    else if (expire)
      cnt_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= SYNC;
      vs1_q   <= ~VS_POL;
      vs2_q   <= ~VS_POL;
      pend_q  <= 1'b0;
      sw_q    <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      vs1_q   <= VGA_VS;
      vs2_q   <= vs1_q;
      pend_q  <= pend_d;
      sw_q    <= sw_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  end

  assign PAT_SEL   = sel_q;
  assign SWITCH    = sw_q;
  assign FRAME_CNT = cnt_q;
  assign LOCKED    = (state_q == SHOW);
endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// tb_vga_pattern_sequencer: directed checks of reset, auto/step advance, collision, VS loss and malformed frames
module tb_vga_pattern_sequencer;
  logic       CLK = 1'b0;
  logic       RST, VGA_VS, VGA_DE, AUTO, STEP;
  logic [1:0] PAT_SEL;
  logic       SWITCH, LOCKED;
  logic [7:0] FRAME_CNT;
  int         errors = 0;
  int         checks = 0;

  vga_pattern_sequencer #(
    .NUM_PAT(4), .SEL_W(2), .HOLD_FRAMES(3), .CNT_W(8), .VS_POL(1'b0), .VS_TIMEOUT(2000)
  ) dut (
    .CLK(CLK), .RST(RST), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE), .AUTO(AUTO), .STEP(STEP),
    .PAT_SEL(PAT_SEL), .SWITCH(SWITCH), .FRAME_CNT(FRAME_CNT), .LOCKED(LOCKED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One frame: VS low for one cycle; outputs sampled on the negedge after the update edge.
  task automatic vs_frame(input string tag, input int len, input logic st, input logic de,
                          input int ep, input int es, input int ec, input int el);
    VGA_VS = 1'b0;
    VGA_DE = de;
    @(negedge CLK);
    chk({tag, "_presw"}, SWITCH, 0);
    VGA_VS = 1'b1;
    STEP   = st;
    @(negedge CLK);
    STEP   = 1'b0;
    VGA_DE = 1'b0;
    chk({tag, "_pat"}, PAT_SEL, ep);
    chk({tag, "_sw"}, SWITCH, es);
    chk({tag, "_cnt"}, FRAME_CNT, ec);
    chk({tag, "_lock"}, LOCKED, el);
    @(negedge CLK);
    chk({tag, "_swoff"}, SWITCH, 0);
    idle(len - 3);
  endtask

  task automatic step_pulse();
    STEP = 1'b1;
    @(negedge CLK);
    STEP = 1'b0;
  endtask

  initial begin
    RST = 1'b0; VGA_VS = 1'b1; VGA_DE = 1'b1; AUTO = 1'b0; STEP = 1'b0;
    idle(10);
    chk("rst_pat", PAT_SEL, 0);
    chk("rst_sw", SWITCH, 0);
    chk("rst_cnt", FRAME_CNT, 0);
    chk("rst_lock", LOCKED, 0);
    RST = 1'b1;
    VGA_DE = 1'b0;
    idle(5);
    chk("sync_lock", LOCKED, 0);
    vs_frame("first", 1000, 1'b0, 1'b0, 0, 0, 0, 1);

    AUTO = 1'b1;
    for (int i = 1; i <= 14; i++)
      vs_frame($sformatf("auto%0d", i), 1000, 1'b0, 1'b0, (i / 3) % 4, (i % 3 == 0) ? 1 : 0, i % 3, 1);

    AUTO = 1'b0;
    idle(100);
    repeat (3) begin
      step_pulse();
      idle(50);
    end
    vs_frame("step", 1000, 1'b0, 1'b0, 1, 1, 0, 1);
    vs_frame("step_once", 1000, 1'b0, 1'b0, 1, 0, 1, 1);

    AUTO = 1'b1;
    vs_frame("coll_pre", 1000, 1'b0, 1'b0, 1, 0, 2, 1);
    vs_frame("coll", 1000, 1'b1, 1'b0, 2, 1, 0, 1);
    vs_frame("coll_f1", 1000, 1'b0, 1'b0, 2, 0, 1, 1);
    vs_frame("coll_f2", 1000, 1'b0, 1'b0, 2, 0, 2, 1);
    vs_frame("coll_f3", 1000, 1'b0, 1'b0, 3, 1, 0, 1);

    AUTO = 1'b0;
    vs_frame("last_fb", 3, 1'b0, 1'b0, 3, 0, 1, 1);
    idle(1998);
    chk("loss_1999_lock", LOCKED, 1);
    idle(1);
    chk("loss_2000_lock", LOCKED, 0);
    chk("loss_cnt", FRAME_CNT, 0);
    chk("loss_pat", PAT_SEL, 3);
    step_pulse();
    idle(498);
    vs_frame("resume", 1000, 1'b0, 1'b0, 3, 0, 0, 1);
    vs_frame("sync_step", 1000, 1'b0, 1'b0, 0, 1, 0, 1);

    vs_frame("malformed", 500, 1'b0, 1'b1, 0, 0, 0, 1);
    vs_frame("after_mal", 1000, 1'b0, 1'b0, 0, 0, 1, 1);
    for (int i = 2; i <= 5; i++)
      vs_frame($sformatf("manual%0d", i), 1000, 1'b0, 1'b0, 0, 0, i, 1);
    AUTO = 1'b1;
    vs_frame("auto_on", 1000, 1'b0, 1'b0, 1, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
